// File: rtl/uart_byte_fifo.sv
// Byte FIFO between uart_receiver and uart_transmitter: edge-detects rx/tx done levels,
// queues received bytes and hands them to the transmitter one at a time.
module uart_byte_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              CLKIN,
    input  logic              RESET,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic              rx_run,
    output logic [7:0]        tx_data,
    output logic              tx_run,
    input  logic              tx_done,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_run_q, tx_run_d;
    logic              ovf_q, ovf_d;
    logic              rx_done_q, tx_done_q;
    state_t            state_q, state_d;
    logic              push_evt, done_evt, pop, wr_en;

    assign push_evt = rx_done & ~rx_done_q;
    assign done_evt = tx_done & ~tx_done_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign rx_run   = ~full;
    assign count    = count_q;
    assign tx_data  = tx_data_q;
    assign tx_run   = tx_run_q;
    assign overflow = ovf_q;

    always_comb begin
        state_d   = state_q;
        tx_run_d  = tx_run_q;
        tx_data_d = tx_data_q;
        rd_ptr_d  = rd_ptr_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: if (!empty) begin
                pop       = 1'b1;
                tx_data_d = mem_q[rd_ptr_q];
                rd_ptr_d  = rd_ptr_q + PTR_ONE;
                tx_run_d  = 1'b1;
                state_d   = SEND;
            end
            SEND: if (done_evt) begin
                tx_run_d = 1'b0;
                state_d  = DRAIN;
            end
            // Wait out a done level left high so it cannot end the next byte early.
            DRAIN: if (!tx_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A push while full is still accepted when a pop frees a slot on the same edge.
    always_comb begin
        wr_en    = push_evt & (~full | pop);
        ovf_d    = ovf_q | (push_evt & full & ~pop);
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        count_d  = count_q;
        if (wr_en && !pop)      count_d = count_q + CNT_ONE;
        else if (!wr_en && pop) count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            state_q   <= IDLE;
            tx_run_q  <= 1'b0;
            tx_data_q <= 8'h00;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            rx_done_q <= 1'b1;
            tx_done_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            tx_run_q  <= tx_run_d;
            tx_data_q <= tx_data_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            rx_done_q <= rx_done;
            tx_done_q <= tx_done;
        end
    end

    always_ff @(posedge CLKIN) begin
        if (wr_en && !RESET) mem_q[wr_ptr_q] <= rx_data;
    end

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Bench for uart_byte_fifo: vector table, directed corner sequences and random traffic
// checked every cycle against a queue-based reference model.
module tb_uart_byte_fifo;
    localparam int DEPTH = 16;

    logic       CLKIN = 1'b0, RESET = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0, tx_done = 1'b0;
    logic       rx_run, tx_run, empty, full, overflow;
    logic [7:0] tx_data;
    logic [4:0] count;

    uart_byte_fifo #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
        .CLKIN(CLKIN), .RESET(RESET), .rx_data(rx_data), .rx_done(rx_done),
        .rx_run(rx_run), .tx_data(tx_data), .tx_run(tx_run), .tx_done(tx_done),
        .count(count), .empty(empty), .full(full), .overflow(overflow));

    always #5 CLKIN = ~CLKIN;

    int checks = 0, errors = 0;

    // Reference model: a queue of waiting bytes plus the transmitter handshake phase
    // (0 = waiting for a byte, 1 = byte offered, 2 = waiting for done to fall).
    logic [7:0] mq[$];
    int         m_ph = 0;
    logic       m_run = 0, m_ovf = 0, m_rxq = 1, m_txq = 1;
    logic [7:0] m_data = 8'h00;
    logic [7:0] txlog[$];
    logic       prev_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        logic push, done, pop, accept;
        if (RESET) begin
            mq.delete(); m_ph = 0; m_run = 0; m_data = 8'h00; m_ovf = 0; m_rxq = 1; m_txq = 1;
            return;
        end
        push   = rx_done && !m_rxq;
        done   = tx_done && !m_txq;
        pop    = (m_ph == 0) && (mq.size() > 0);
        accept = push && ((mq.size() < DEPTH) || pop);
        if (push && !accept) m_ovf = 1;
        if (pop) begin
            m_data = mq.pop_front(); m_run = 1; m_ph = 1;
        end else if (m_ph == 1 && done) begin
            m_run = 0; m_ph = 2;
        end else if (m_ph == 2 && !tx_done) begin
            m_ph = 0;
        end
        if (accept) mq.push_back(rx_data);
        m_rxq = rx_done; m_txq = tx_done;
    endtask

    task automatic cyc();
        model_step();
        @(posedge CLKIN); #1;
        chk("tx_run",   tx_run,   m_run);
        chk("tx_data",  tx_data,  m_data);
        chk("count",    count,    mq.size());
        chk("empty",    empty,    mq.size() == 0);
        chk("full",     full,     mq.size() == DEPTH);
        chk("rx_run",   rx_run,   mq.size() != DEPTH);
        chk("overflow", overflow, m_ovf);
        if (tx_run && !prev_run) txlog.push_back(tx_data);
        prev_run = tx_run;
    endtask

    task automatic do_reset();
        RESET = 1; rx_done = 0; tx_done = 0;
        cyc();
        RESET = 0;
        cyc();
        txlog.delete();
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_data = b; rx_done = 1; cyc();
        rx_done = 0; cyc();
    endtask

    task automatic wait_run();
        int n = 0;
        while (!tx_run && n < 100) begin cyc(); n++; end
        if (!tx_run) begin
            checks++; errors++;
            $display("FAIL wait_run timeout at %0t", $time);
        end
    endtask

    task automatic ack();
        wait_run();
        tx_done = 1; cyc();
        tx_done = 0; cyc();
    endtask

    typedef struct {
        logic       rst, rxdn, txdn;
        logic [7:0] rxd;
        logic       exp_run;
        logic [7:0] exp_data;
        logic [4:0] exp_cnt;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl[9];

    initial begin
        // Single-byte handshake, cycle by cycle.
        tbl[0] = '{1, 0, 0, 8'h00, 0, 8'h00, 0, 0};
        tbl[1] = '{0, 0, 0, 8'h00, 0, 8'h00, 0, 0};
        tbl[2] = '{0, 1, 0, 8'hA5, 0, 8'h00, 1, 0};
        tbl[3] = '{0, 0, 0, 8'h00, 1, 8'hA5, 0, 0};
        tbl[4] = '{0, 0, 0, 8'h00, 1, 8'hA5, 0, 0};
        tbl[5] = '{0, 0, 1, 8'h00, 0, 8'hA5, 0, 0};
        tbl[6] = '{0, 0, 1, 8'h00, 0, 8'hA5, 0, 0};
        tbl[7] = '{0, 0, 0, 8'h00, 0, 8'hA5, 0, 0};
        tbl[8] = '{0, 0, 0, 8'h00, 0, 8'hA5, 0, 0};
        for (int i = 0; i < 9; i++) begin
            RESET = tbl[i].rst; rx_done = tbl[i].rxdn; tx_done = tbl[i].txdn; rx_data = tbl[i].rxd;
            cyc();
            chk($sformatf("vec%0d_run", i),  tx_run,   tbl[i].exp_run);
            chk($sformatf("vec%0d_data", i), tx_data,  tbl[i].exp_data);
            chk($sformatf("vec%0d_cnt", i),  count,    tbl[i].exp_cnt);
            chk($sformatf("vec%0d_ovf", i),  overflow, tbl[i].exp_ovf);
            if (i == 0) chk("reset_rx_run", rx_run, 1);
        end
        chk("single_empty", empty, 1);

        // Ordering across pointer wrap.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            push_byte(8'(i));
            ack();
        end
        chk("order_len", txlog.size(), 20);
        for (int i = 0; i < txlog.size() && i < 20; i++) chk("order_byte", txlog[i], i);
        chk("order_ovf", overflow, 0);

        // Fill, overflow, drain.
        do_reset();
        for (int i = 0; i < 17; i++) push_byte(8'(8'h10 + i));
        chk("full_cnt", count, 16);
        chk("full_flag", full, 1);
        chk("full_rxrun", rx_run, 0);
        chk("full_inflight", tx_data, 8'h10);
        push_byte(8'hFF);
        chk("ovf_set", overflow, 1);
        chk("ovf_cnt", count, 16);
        for (int i = 0; i < 17; i++) ack();
        repeat (4) cyc();
        chk("drain_len", txlog.size(), 17);
        for (int i = 0; i < txlog.size() && i < 17; i++) chk("drain_byte", txlog[i], 8'h10 + i);
        chk("drain_ovf", overflow, 1);
        chk("drain_empty", empty, 1);

        // Stuck done plus push coinciding with pop.
        do_reset();
        push_byte(8'h30);
        for (int i = 1; i <= 3; i++) push_byte(8'(8'h30 + i));
        chk("sim_cnt3", count, 3);
        tx_done = 1;
        cyc();
        chk("stuck_drop", tx_run, 0);
        repeat (3) begin cyc(); chk("stuck_hold", tx_run, 0); end
        tx_done = 0;
        cyc();
        chk("stuck_idle", tx_run, 0);
        rx_data = 8'h77; rx_done = 1;
        cyc();
        rx_done = 0;
        chk("sim_run", tx_run, 1);
        chk("sim_data", tx_data, 8'h31);
        chk("sim_cnt", count, 3);
        for (int i = 0; i < 4; i++) ack();
        repeat (3) cyc();
        chk("sim_len", txlog.size(), 5);
        if (txlog.size() == 5) chk("sim_last", txlog[4], 8'h77);

        // Reset in the middle of a transfer with rx_done held high.
        do_reset();
        for (int i = 0; i < 6; i++) push_byte(8'(8'h50 + i));
        chk("mid_cnt", count, 5);
        chk("mid_run", tx_run, 1);
        RESET = 1; rx_done = 1;
        cyc();
        chk("rst_run", tx_run, 0);
        chk("rst_cnt", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_rxrun", rx_run, 1);
        RESET = 0;
        cyc(); cyc();
        chk("rst_nopush", count, 0);
        chk("rst_norun", tx_run, 0);
        rx_done = 0;
        cyc();

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            RESET   = ($urandom_range(0, 599) == 0);
            rx_done = ($urandom_range(0, 2) == 0);
            rx_data = 8'($urandom);
            tx_done = (i < 1500) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
            cyc();
        end
        RESET = 0; rx_done = 0; tx_done = 0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
